// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window path: image geometry,
// pixel width and the slot phases the feeder shares with the line buffer.
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int CNT_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Slot kinds of one frame as seen by the line buffer.
    typedef enum logic [1:0] {
        PIX   = 2'd0,  // real pixel slot
        PADC  = 2'd1,  // right-pad slot after a row
        PADR  = 2'd2,  // bottom-pad row slot
        PADRC = 2'd3   // right-pad slot after the bottom-pad row
    } phase_t;

endpackage

// File: rtl/conv_sync_fifo.sv
// Small synchronous FIFO with count-based full/empty and a synchronous clear.
// A push is ignored when full and a pop is ignored when empty.
module conv_sync_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   clear,
    input  logic   push,
    input  logic   pop,
    input  pixel_t wr_data,
    output pixel_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push,  do_pop;
    pixel_t        mem_q [DEPTH];

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; clear wins over push and pop.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        do_push  = push && !full && !clear;
        do_pop   = pop && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage write; the array carries no reset since count_q alone decides what is valid.
    always_ff @(posedge clock) begin
        // NOTE: data storage is deliberately left out of reset; only control state is reset.
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/conv_pixel_feeder.sv
// Source-side driver for the 3x3 line buffer: buffers the upstream raster
// stream and interleaves the enable-only pad slots (right pad per row, bottom
// pad row plus its right pad per frame) that the line buffer expects.
module conv_pixel_feeder
    import conv_pkg::*;
#(
    parameter int W     = IMG_W,
    parameter int H     = IMG_H,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             buf_ena,
    output logic [PIX_W-1:0] buf_pixel,
    output logic             pad_slot,
    output logic             frame_done
);

    localparam cnt_t COL_LAST = CNT_W'(W - 1);
    localparam cnt_t ROW_LAST = CNT_W'(H - 1);

    phase_t phase_q, phase_d;
    cnt_t   col_q,   col_d;
    cnt_t   row_q,   row_d;
    logic   frame_done_q, frame_done_d;

    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    pixel_t fifo_head;

    conv_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Handshake and line-buffer drive: pad slots always strobe, pixel slots only with data.
    always_comb begin
        in_ready  = !fifo_full;
        fifo_push = in_valid && !fifo_full && !clear;
        pad_slot  = (phase_q != PIX);
        buf_ena   = (phase_q == PIX) ? !fifo_empty : 1'b1;
        fifo_pop  = (phase_q == PIX) && !fifo_empty;
        buf_pixel = ((phase_q == PIX) && !fifo_empty) ? fifo_head : '0;
    end

    // Slot sequencing: advance only on strobed cycles so a stalled pixel slot holds position.
    always_comb begin
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (clear) begin
            phase_d = PIX;
            col_d   = '0;
            row_d   = '0;
        end else if (buf_ena) begin
            case (phase_q)
                PIX: begin
                    if (col_q == COL_LAST) phase_d = PADC;
                    else                   col_d   = col_q + 1'b1;
                end
                PADC: begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        phase_d = PADR;
                    end else begin
                        row_d   = row_q + 1'b1;
                        phase_d = PIX;
                    end
                end
                PADR: begin
                    if (col_q == COL_LAST) phase_d = PADRC;
                    else                   col_d   = col_q + 1'b1;
                end
                PADRC: begin
                    col_d        = '0;
                    phase_d      = PIX;
                    frame_done_d = 1'b1;
                end
                default: phase_d = PIX;
            endcase
        end
    end

    // Phase, position and end-of-frame pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q      <= PIX;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

endmodule
